// File: rtl/fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sched
//  Description : Round-robin scheduler sharing one multiply-accumulate engine
//                between several FIR channels. The granted channel streams a
//                burst of coefficient x sample products. The dequantized sum
//                is returned tagged with the channel index.
//                Optional macro FIR_MAC_SCHED_SATURATE_EN: accumulator
//                saturates instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QUANT_BITS = 10,
    parameter int MAX_TAPS   = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            op_valid,
    input  logic [NUM_REQ-1:0]            op_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] coeff_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] sample_in,
    output logic [NUM_REQ-1:0]            grant,
    output logic [DATA_WIDTH-1:0]         result,
    output logic [$clog2(NUM_REQ)-1:0]    result_id,
    output logic                          result_valid,
    input  logic                          result_ready,
    output logic                          overrun
);

    localparam int c_id_width   = $clog2(NUM_REQ);
    localparam int c_cnt_width  = $clog2(MAX_TAPS + 1);
    localparam int c_prod_width = 2 * DATA_WIDTH;
    localparam logic [c_cnt_width-1:0] c_max_taps = c_cnt_width'(MAX_TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered state
    state_t                    r_state;
    logic [c_id_width-1:0]     r_gidx;
    logic [NUM_REQ-1:0]        r_grant;
    logic [c_id_width-1:0]     r_ptr;
    logic [DATA_WIDTH-1:0]     r_acc;
    logic [c_cnt_width-1:0]    r_count;
    logic [DATA_WIDTH-1:0]     r_result;
    logic [c_id_width-1:0]     r_result_id;
    logic                      r_result_valid;
    logic                      r_overrun;

    // Next-state values
    state_t                    w_state_next;
    logic [c_id_width-1:0]     w_gidx_next;
    logic [NUM_REQ-1:0]        w_grant_next;
    logic [c_id_width-1:0]     w_ptr_next;
    logic [DATA_WIDTH-1:0]     w_acc_next;
    logic [c_cnt_width-1:0]    w_count_next;
    logic [DATA_WIDTH-1:0]     w_result_next;
    logic [c_id_width-1:0]     w_result_id_next;
    logic                      w_result_valid_next;
    logic                      w_overrun_next;

    // Datapath and arbitration wires
    logic                          w_arb_found;
    logic [c_id_width-1:0]         w_arb_idx;
    logic                          w_op_valid;
    logic                          w_op_last;
    logic                          w_req;
    logic [DATA_WIDTH-1:0]         w_coeff;
    logic [DATA_WIDTH-1:0]         w_sample;
    logic signed [c_prod_width-1:0] w_prod;
    logic [DATA_WIDTH-1:0]         w_term;
    logic [DATA_WIDTH-1:0]         w_acc_upd;
    logic [c_cnt_width-1:0]        w_count_inc;

    // Channel index base+offs, wrapped into 0..NUM_REQ-1
    function automatic logic [c_id_width-1:0] wrap_idx(input logic [c_id_width-1:0] base,
                                                       input int offs);
        int k;
        k = int'(base) + offs;
        if (k >= NUM_REQ) begin
            k = k - NUM_REQ;
        end
        return c_id_width'(k);
    endfunction

    // Round-robin pick: first requester after the last served channel
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!w_arb_found && req[wrap_idx(r_ptr, i)]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = wrap_idx(r_ptr, i);
            end
        end
    end

    // Only the granted channel's controls and operands reach the MAC
    assign w_op_valid = op_valid[r_gidx];
    assign w_op_last  = op_last[r_gidx];
    assign w_req      = req[r_gidx];
    assign w_coeff    = coeff_in[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sample   = sample_in[int'(r_gidx)*DATA_WIDTH +: DATA_WIDTH];

    // Full-width signed product, dequantized then truncated to operand width
    assign w_prod      = $signed(w_coeff) * $signed(w_sample);
    assign w_term      = DATA_WIDTH'(w_prod >>> QUANT_BITS);
    assign w_count_inc = r_count + 1'b1;

`ifdef FIR_MAC_SCHED_SATURATE_EN
    localparam logic [DATA_WIDTH-1:0] c_sat_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_sat_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic [DATA_WIDTH:0] w_sum_ext;

    // Accumulate with one guard bit; clamp when the guard disagrees with the sign
    always_comb begin
        w_sum_ext = {r_acc[DATA_WIDTH-1], r_acc} + {w_term[DATA_WIDTH-1], w_term};
        if (w_sum_ext[DATA_WIDTH] != w_sum_ext[DATA_WIDTH-1]) begin
            w_acc_upd = w_sum_ext[DATA_WIDTH] ? c_sat_min : c_sat_max;
        end else begin
            w_acc_upd = w_sum_ext[DATA_WIDTH-1:0];
        end
    end
`else
    // Accumulate with two's-complement wrap
    assign w_acc_upd = r_acc + w_term;
`endif

    // Next-state and next-output logic for the IDLE/BUSY/DONE sequence
    always_comb begin
        w_state_next        = r_state;
        w_gidx_next         = r_gidx;
        w_grant_next        = r_grant;
        w_ptr_next          = r_ptr;
        w_acc_next          = r_acc;
        w_count_next        = r_count;
        w_result_next       = r_result;
        w_result_id_next    = r_result_id;
        w_result_valid_next = r_result_valid;
        w_overrun_next      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_found) begin
                    w_gidx_next  = w_arb_idx;
                    w_grant_next = NUM_REQ'(1) << w_arb_idx;
                    w_acc_next   = '0;
                    w_count_next = '0;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_op_valid) begin
                    w_acc_next   = w_acc_upd;
                    w_count_next = w_count_inc;
                    // Tap limit closes the burst even without op_last
                    if (w_op_last || (w_count_inc == c_max_taps)) begin
                        w_result_next       = w_acc_upd;
                        w_result_id_next    = r_gidx;
                        w_result_valid_next = 1'b1;
                        w_overrun_next      = ~w_op_last;
                        w_state_next        = DONE;
                    end
                end else if (!w_req) begin
                    // Channel withdrew mid-burst: discard partial sum
                    w_grant_next = '0;
                    w_ptr_next   = r_gidx;
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    w_grant_next        = '0;
                    w_result_valid_next = 1'b0;
                    w_ptr_next          = r_gidx;
                    w_state_next        = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_gidx         <= '0;
            r_grant        <= '0;
            r_ptr          <= c_id_width'(NUM_REQ - 1);
            r_acc          <= '0;
            r_count        <= '0;
            r_result       <= '0;
            r_result_id    <= '0;
            r_result_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_gidx         <= w_gidx_next;
            r_grant        <= w_grant_next;
            r_ptr          <= w_ptr_next;
            r_acc          <= w_acc_next;
            r_count        <= w_count_next;
            r_result       <= w_result_next;
            r_result_id    <= w_result_id_next;
            r_result_valid <= w_result_valid_next;
            r_overrun      <= w_overrun_next;
        end
    end

    assign grant        = r_grant;
    assign result       = r_result;
    assign result_id    = r_result_id;
    assign result_valid = r_result_valid;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_mac_sched
//  Description : Self-checking bench for fir_mac_sched (4 channels, 32-bit,
//                QUANT_BITS=10, MAX_TAPS=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sched;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       op_valid;
    logic [NUM_REQ-1:0]       op_last;
    logic [NUM_REQ*DW-1:0]    coeff_in;
    logic [NUM_REQ*DW-1:0]    sample_in;
    logic [NUM_REQ-1:0]       grant;
    logic [DW-1:0]            result;
    logic [1:0]               result_id;
    logic                     result_valid;
    logic                     result_ready;
    logic                     overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int             ch;
        int             n;
        logic [31:0]    coeff;
        logic [3:0][31:0] samp;
        logic [31:0]    exp;
        int             hold;
    } vec_t;

    fir_mac_sched #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .QUANT_BITS (10),
        .MAX_TAPS   (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .op_valid     (op_valid),
        .op_last      (op_last),
        .coeff_in     (coeff_in),
        .sample_in    (sample_in),
        .grant        (grant),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
        end
    endtask

    task automatic set_op(input int ch, input logic v, input logic last,
                          input logic [31:0] c, input logic [31:0] s);
        op_valid[ch]         = v;
        op_last[ch]          = last;
        coeff_in[ch*DW +: DW]  = c;
        sample_in[ch*DW +: DW] = s;
    endtask

    task automatic wait_grant(input int ch, output int lat);
        lat = 0;
        while (grant[ch] !== 1'b1 && lat < 16) begin
            tick();
            lat++;
        end
    endtask

    function automatic vec_t mk(input int ch, input int n, input logic [31:0] c,
                                input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3,
                                input logic [31:0] e, input int hold);
        vec_t v;
        v.ch    = ch;
        v.n     = n;
        v.coeff = c;
        v.samp  = {s3, s2, s1, s0};
        v.exp   = e;
        v.hold  = hold;
        return v;
    endfunction

    task automatic run_burst(input vec_t v);
        int lat;
        req[v.ch] = 1'b1;
        wait_grant(v.ch, lat);
        check("grant_latency", lat, 1);
        check("grant_onehot", {28'd0, grant}, 32'd1 << v.ch);
        for (int k = 0; k < v.n; k++) begin
            set_op(v.ch, 1'b1, (k == v.n - 1), v.coeff, v.samp[k]);
            tick();
            if (k < v.n - 1) begin
                check("early_result_valid", {31'd0, result_valid}, 0);
            end
        end
        set_op(v.ch, 1'b0, 1'b0, 32'd0, 32'd0);
        check("result_valid", {31'd0, result_valid}, 1);
        check("result", result, v.exp);
        check("result_id", {30'd0, result_id}, v.ch);
        check("no_overrun", {31'd0, overrun}, 0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check("hold_result", result, v.exp);
            check("hold_valid", {31'd0, result_valid}, 1);
            check("hold_grant", {28'd0, grant}, 32'd1 << v.ch);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        req[v.ch]    = 1'b0;
        check("accept_valid_drop", {31'd0, result_valid}, 0);
        check("accept_grant_drop", {28'd0, grant}, 0);
    endtask

    vec_t vecs[9];
    int   rr_seq[6];

    initial begin
        int lat;
        int g;
        logic early;

        vecs[0] = mk(2, 3, 32'd1024, 32'd5, 32'd7, -32'sd3, 32'd0, 32'd9, 4);
        vecs[1] = mk(1, 2, 32'd512, 32'd10, 32'd20, 32'd0, 32'd0, 32'd15, 0);
        vecs[2] = mk(3, 1, -32'sd1024, 32'd100, 32'd0, 32'd0, 32'd0, 32'hFFFF_FF9C, 1);
        vecs[3] = mk(0, 4, 32'd3072, -32'sd1, -32'sd1, -32'sd1, 32'd2, 32'hFFFF_FFFD, 0);
        vecs[4] = mk(2, 4, 32'd1, 32'd1023, 32'd1023, 32'd1023, 32'd1023, 32'd0, 0);
        vecs[5] = mk(1, 1, 32'd1, -32'sd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        vecs[6] = mk(3, 4, 32'h4000_0000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h0000_0000, 0);
`ifdef FIR_MAC_SCHED_SATURATE_EN
        vecs[7] = mk(0, 2, 32'h4000_0000, 32'h400, 32'h400, 32'd0, 32'd0, 32'h7FFF_FFFF, 0);
`else
        vecs[7] = mk(0, 2, 32'h4000_0000, 32'h400, 32'h400, 32'd0, 32'd0, 32'h8000_0000, 0);
`endif
        vecs[8] = mk(1, 3, -32'sd2048, 32'd3, -32'sd4, 32'd7, 32'd0, 32'hFFFF_FFF4, 2);
        rr_seq  = '{0, 1, 3, 0, 1, 3};

        req          = '0;
        op_valid     = '0;
        op_last      = '0;
        coeff_in     = '0;
        sample_in    = '0;
        result_ready = 1'b0;

        // Reset held with all channels requesting
        reset = 1'b0;
        req   = 4'b1111;
        tick(); tick(); tick();
        check("reset_grant", {28'd0, grant}, 0);
        check("reset_valid", {31'd0, result_valid}, 0);
        check("reset_result", result, 0);
        check("reset_id", {30'd0, result_id}, 0);
        check("reset_overrun", {31'd0, overrun}, 0);
        reset = 1'b1;
        tick();
        check("first_grant_ch0", {28'd0, grant}, 32'd1);
        req = '0;
        tick();
        check("idle_abort_grant", {28'd0, grant}, 0);

        // Table-driven single-channel bursts
        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i]);
        end

        // Round-robin with three channels requesting continuously
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        req   = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            lat = 0;
            while (grant === 4'd0 && lat < 8) begin
                tick();
                lat++;
            end
            check("rr_grant", {28'd0, grant}, 32'd1 << rr_seq[i]);
            check("rr_latency", lat, 1);
            g = 0;
            for (int c = 0; c < NUM_REQ; c++) begin
                if (grant[c]) g = c;
            end
            set_op(g, 1'b1, 1'b1, 32'd1024, 32'(i + 1));
            tick();
            set_op(g, 1'b0, 1'b0, 32'd0, 32'd0);
            check("rr_result_id", {30'd0, result_id}, rr_seq[i]);
            check("rr_result", result, 32'(i + 1));
            result_ready = 1'b1;
            tick();
            result_ready = 1'b0;
            check("rr_gap", {28'd0, grant}, 0);
        end
        req = '0;
        tick();

        // Overrun: 32 products without op_last
        req[0] = 1'b1;
        wait_grant(0, lat);
        check("ovr_grant", {28'd0, grant}, 32'd1);
        early = 1'b0;
        for (int k = 0; k < 32; k++) begin
            set_op(0, 1'b1, 1'b0, 32'd2048, 32'd1);
            tick();
            if (k < 31 && (overrun || result_valid)) early = 1'b1;
        end
        set_op(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("ovr_not_early", {31'd0, early}, 0);
        check("ovr_valid", {31'd0, result_valid}, 1);
        check("ovr_pulse", {31'd0, overrun}, 1);
        check("ovr_result", result, 32'd64);
        check("ovr_id", {30'd0, result_id}, 0);
        tick();
        check("ovr_pulse_once", {31'd0, overrun}, 0);
        check("ovr_valid_hold", {31'd0, result_valid}, 1);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        req = '0;
        tick();

        // Abort: ch1 withdraws after two products
        req[1] = 1'b1;
        wait_grant(1, lat);
        check("abort_grant", {28'd0, grant}, 32'd2);
        set_op(1, 1'b1, 1'b0, 32'd1024, 32'd1);
        tick();
        tick();
        set_op(1, 1'b0, 1'b0, 32'd0, 32'd0);
        req[1] = 1'b0;
        tick();
        check("abort_grant_drop", {28'd0, grant}, 0);
        check("abort_no_valid", {31'd0, result_valid}, 0);
        req[0] = 1'b1;
        tick();
        check("after_abort_grant", {28'd0, grant}, 32'd1);
        set_op(1, 1'b1, 1'b1, 32'd1024, 32'd99);
        tick();
        check("foreign_op_ignored", {31'd0, result_valid}, 0);
        check("foreign_grant_kept", {28'd0, grant}, 32'd1);
        set_op(0, 1'b1, 1'b1, 32'd1024, 32'd42);
        tick();
        set_op(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_op(1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("after_abort_result", result, 32'd42);
        check("after_abort_id", {30'd0, result_id}, 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        req = '0;
        tick();

        // Reset in the middle of a burst
        req[2] = 1'b1;
        wait_grant(2, lat);
        set_op(2, 1'b1, 1'b0, 32'd1024, 32'd5);
        tick();
        reset = 1'b0;
        tick();
        check("midreset_grant", {28'd0, grant}, 0);
        check("midreset_valid", {31'd0, result_valid}, 0);
        check("midreset_result", result, 0);
        reset = 1'b1;
        req   = '0;
        set_op(2, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        check("midreset_idle", {28'd0, grant}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
